// File: rtl/wshb_arbiter_rr.sv
// Round-robin Wishbone arbiter: NM masters share one slave port with registered ownership and a combinational mux.
// Define WSHB_ARB_QUOTA_EN to force a hand-off after QUOTA acks while another master is waiting.
module wshb_arbiter_rr #(
  parameter int NM     = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QUOTA  = 64
) (
  input  logic                     wshb_clk,
  input  logic                     wshb_rst,
  input  logic [NM-1:0]            m_cyc,
  input  logic [NM-1:0]            m_stb,
  input  logic [NM-1:0]            m_we,
  input  logic [NM*ADDR_W-1:0]     m_adr,
  input  logic [NM*DATA_W-1:0]     m_dat_w,
  input  logic [NM*DATA_W/8-1:0]   m_sel,
  input  logic [NM*3-1:0]          m_cti,
  input  logic [NM*2-1:0]          m_bte,
  output logic [NM-1:0]            m_ack,
  output logic [NM-1:0]            m_err,
  output logic [DATA_W-1:0]        m_dat_r,
  output logic                     s_cyc,
  output logic                     s_stb,
  output logic                     s_we,
  output logic [ADDR_W-1:0]        s_adr,
  output logic [DATA_W-1:0]        s_dat_w,
  output logic [DATA_W/8-1:0]      s_sel,
  output logic [2:0]               s_cti,
  output logic [1:0]               s_bte,
  input  logic                     s_ack,
  input  logic                     s_err,
  input  logic [DATA_W-1:0]        s_dat_r,
  output logic [NM-1:0]            grant,
  output logic                     dbg_state
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [OW-1:0] last, last_nxt;
  logic [OW:0]   pick;

  // Returns {found, index} of the first requester after 'from', wrapping modulo NM.
  function automatic logic [OW:0] rr_pick(input logic [NM-1:0] req, input logic [OW-1:0] from);
    logic [OW:0]   res;
    logic [OW-1:0] sel;
    int            idx;
    res = '0;
    for (int i = NM; i >= 1; i--) begin
      idx = int'(from) + i;
      if (idx >= NM) idx = idx - NM;
      sel = OW'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

`ifdef WSHB_ARB_QUOTA_EN
  localparam int CW = $clog2(QUOTA + 1);
  logic [CW-1:0] ack_cnt, cnt_sum;
  logic          quota_hit;
  logic          owner_change;

  // Saturating count including the ack completing this cycle, so the hand-off lands on the QUOTA-th ack edge.
  always_comb begin
    cnt_sum = ack_cnt;
    if (s_cyc && s_ack && (ack_cnt != CW'(QUOTA))) cnt_sum = ack_cnt + CW'(1);
    quota_hit = (cnt_sum == CW'(QUOTA));
  end

  assign owner_change = (state != OWNED) || (state_nxt != OWNED) || (owner_nxt != owner);

  always_ff @(posedge wshb_clk or posedge wshb_rst) begin
    if (wshb_rst)          ack_cnt <= '0;
    else if (owner_change) ack_cnt <= '0;
    else                   ack_cnt <= cnt_sum;
  end
`endif

  always_ff @(posedge wshb_clk or posedge wshb_rst) begin
    if (wshb_rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(NM - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    pick      = '0;
    case (state)
      IDLE: begin
        pick = rr_pick(m_cyc, last);
        if (pick[OW]) begin
          state_nxt = OWNED;
          owner_nxt = pick[OW-1:0];
          last_nxt  = pick[OW-1:0];
        end
      end
      OWNED: begin
        // Owner released: hand straight to the next requester, or go idle.
        if (!s_cyc) begin
          pick = rr_pick(m_cyc & ~grant, last);
          if (pick[OW]) begin
            owner_nxt = pick[OW-1:0];
            last_nxt  = pick[OW-1:0];
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef WSHB_ARB_QUOTA_EN
        else if (quota_hit && (|(m_cyc & ~grant))) begin
          pick      = rr_pick(m_cyc & ~grant, last);
          owner_nxt = pick[OW-1:0];
          last_nxt  = pick[OW-1:0];
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wishbone handshake: a beat completes on the edge where s_cyc & s_stb & s_ack are all high;
  // the slave owns the ack timing and only the current owner ever sees ack/err.
  always_comb begin
    grant   = '0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    for (int i = 0; i < NM; i++) begin
      grant[i] = (state == OWNED) && (owner == OW'(i));
      if (grant[i]) begin
        s_we    = m_we[i];
        s_adr   = m_adr[i*ADDR_W +: ADDR_W];
        s_dat_w = m_dat_w[i*DATA_W +: DATA_W];
        s_sel   = m_sel[i*SW +: SW];
        s_cti   = m_cti[i*3 +: 3];
        s_bte   = m_bte[i*2 +: 2];
      end
    end
    s_cyc   = |(grant & m_cyc);
    s_stb   = s_cyc & (|(grant & m_stb));
    m_ack   = grant & {NM{s_ack}};
    m_err   = grant & {NM{s_err}};
    m_dat_r = s_dat_r;
  end

  assign dbg_state = (state == OWNED);

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench for wshb_arbiter_rr: a per-master transaction engine, a zero-wait slave and a beat scoreboard.
// Build with WSHB_ARB_QUOTA_EN defined to exercise the quota hand-off (QUOTA=4).
module tb_wshb_arbiter_rr;

  localparam int W = 70;

  logic        wshb_clk = 1'b0;
  logic        wshb_rst;
  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [63:0] m_adr, m_dat_w;
  logic [7:0]  m_sel;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [31:0] m_dat_r, s_adr, s_dat_w, s_dat_r;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, dbg_state;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;

  // clock / slave model
  always #5 wshb_clk = ~wshb_clk;

  logic slave_en, s_ack_f, s_err_f;
  assign s_ack   = (s_cyc & s_stb & slave_en) | s_ack_f;
  assign s_err   = s_err_f;
  assign s_dat_r = s_adr ^ 32'h5a5a_5a5a;

  logic [1:0]  cyc_d, stb_d, we_d;
  logic [31:0] adr_d[2];
  logic [2:0]  cti_d[2];
  assign m_cyc   = cyc_d;
  assign m_stb   = stb_d;
  assign m_we    = we_d;
  assign m_adr   = {adr_d[1], adr_d[0]};
  assign m_dat_w = {~adr_d[1], ~adr_d[0]};
  assign m_cti   = {cti_d[1], cti_d[0]};
  assign m_sel   = 8'hff;
  assign m_bte   = 4'h0;

  wshb_arbiter_rr #(.NM(2), .ADDR_W(32), .DATA_W(32), .QUOTA(4)) dut (
    .wshb_clk(wshb_clk), .wshb_rst(wshb_rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
    .grant(grant), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;

  typedef struct {
    logic [31:0] adr;
    int          beats;
    bit          we;
  } txn_t;

  txn_t mq[2][$];
  int   left[2];
  bit   fin[2];
  bit   acked[2];
  txn_t cur_t;

  logic [1:0] grant_tr[4096];
  bit         scyc_tr[4096];
  int         ncnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int m, input logic [31:0] adr, input bit we,
                                        input logic [2:0] cti);
    return {(m == 0) ? 2'b01 : 2'b10, adr, we, cti, ~adr};
  endfunction

  // Push expected beats [first, first+n) of a 'total'-beat transfer; cti 010 then 111, single = 000.
  task automatic push_beats(input int m, input logic [31:0] base, input int first, input int n,
                            input int total, input bit we);
    logic [2:0] cti;
    for (int k = first; k < first + n; k++) begin
      cti = (total == 1) ? 3'b000 : ((k == total - 1) ? 3'b111 : 3'b010);
      exp_q.push_back(beat(m, base + 32'(4 * k), we, cti));
    end
  endtask

  task automatic issue(input int m, input logic [31:0] adr, input int beats, input bit we);
    txn_t t;
    t.adr   = adr;
    t.beats = beats;
    t.we    = we;
    mq[m].push_back(t);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || left[0] != 0 || left[1] != 0 || mq[0].size() != 0 ||
            mq[1].size() != 0 || fin[0] || fin[1]) && n < 2000) begin
      @(negedge wshb_clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge wshb_clk);
  endtask

  // master driver engine: inputs change 1 time unit after the active edge
  always @(posedge wshb_clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      if (wshb_rst) begin
        cyc_d[m] = 1'b0; stb_d[m] = 1'b0; we_d[m] = 1'b0; cti_d[m] = 3'b000;
        left[m] = 0; fin[m] = 1'b0;
        mq[m].delete();
      end else if (left[m] > 0) begin
        if (acked[m]) begin
          left[m]--;
          adr_d[m] = adr_d[m] + 32'd4;
          if (left[m] == 0) begin
            cyc_d[m] = 1'b0; stb_d[m] = 1'b0; we_d[m] = 1'b0; cti_d[m] = 3'b000;
            fin[m] = 1'b1;
          end else if (left[m] == 1) begin
            cti_d[m] = 3'b111;
          end
        end
      end else if (fin[m]) begin
        fin[m] = 1'b0;
      end else if (mq[m].size() > 0) begin
        cur_t    = mq[m].pop_front();
        cyc_d[m] = 1'b1;
        stb_d[m] = 1'b1;
        we_d[m]  = cur_t.we;
        adr_d[m] = cur_t.adr;
        cti_d[m] = (cur_t.beats == 1) ? 3'b000 : 3'b010;
        left[m]  = cur_t.beats;
      end
    end
  end

  // monitor: samples on the falling edge, pops one expected entry per completed beat
  always @(negedge wshb_clk) begin
    logic [W-1:0] e;
    acked[0] = m_ack[0];
    acked[1] = m_ack[1];
    if (ncnt < 4096) begin
      grant_tr[ncnt] = grant;
      scyc_tr[ncnt]  = s_cyc;
    end
    ncnt++;
    if (!wshb_rst && s_cyc && s_stb && s_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got grant %b adr %h, expected no beat", grant, s_adr);
      end else begin
        e = exp_q.pop_front();
        check("beat", {grant, s_adr, s_we, s_cti, s_dat_w}, e);
        check("ack_route", {m_ack, m_err}, {e[69:68], 2'b00});
        check("rdata", m_dat_r, e[67:36] ^ 32'h5a5a_5a5a);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, jj;
    bit  found;
    wshb_rst = 1'b1;
    slave_en = 1'b1; s_ack_f = 1'b0; s_err_f = 1'b0;
    cyc_d = '0; stb_d = '0; we_d = '0;
    adr_d[0] = '0; adr_d[1] = '0; cti_d[0] = '0; cti_d[1] = '0;
    left[0] = 0; left[1] = 0; fin[0] = 1'b0; fin[1] = 1'b0;
    repeat (3) @(posedge wshb_clk);
    @(negedge wshb_clk);
    check("reset_out", {grant, s_cyc, s_stb, m_ack, m_err, dbg_state, s_adr}, '0);
    @(posedge wshb_clk); #1 wshb_rst = 1'b0;

    // single read at 0x100: one cycle request-to-slave latency, err/ack only to owner
    slave_en = 1'b0;
    issue(0, 32'h100, 1, 1'b0);
    push_beats(0, 32'h100, 0, 1, 1, 1'b0);
    n = 0;
    do begin @(negedge wshb_clk); n++; end while (!m_cyc[0] && n < 20);
    check("req_seen", m_cyc[0], 1'b1);
    check("idle_same_cycle", {s_cyc, grant}, 3'b000);
    @(negedge wshb_clk);
    check("grant_latency", {s_cyc, grant, s_adr, m_ack}, {1'b1, 2'b01, 32'h100, 2'b00});
    #1 s_err_f = 1'b1;
    #1 check("err_route", {m_err, m_ack}, 4'b0100);
    s_err_f = 1'b0;
    @(posedge wshb_clk); #1 slave_en = 1'b1;
    wait_drain("single_read");

    @(posedge wshb_clk); #1 wshb_rst = 1'b1;
    @(posedge wshb_clk); #1 wshb_rst = 1'b0;

    // simultaneous requests: master 0 first, single idle cycle on hand-off
    n = ncnt;
    issue(0, 32'h200, 1, 1'b0);
    issue(1, 32'h300, 1, 1'b1);
    push_beats(0, 32'h200, 0, 1, 1, 1'b0);
    push_beats(1, 32'h300, 0, 1, 1, 1'b1);
    wait_drain("simultaneous");
    found = 1'b0; jj = 0;
    for (int j = n + 2; j < ncnt && j < 4096; j++)
      if (!found && grant_tr[j] == 2'b10 && scyc_tr[j]) begin found = 1'b1; jj = j; end
    check("handoff_found", found, 1'b1);
    if (found) check("handoff_gap", {scyc_tr[jj-2], grant_tr[jj-2], scyc_tr[jj-1]}, 4'b1010);

    // 16-beat burst from master 0 while master 1 waits
    issue(0, 32'h1000, 16, 1'b0);
    issue(1, 32'h2000, 1, 1'b1);
`ifdef WSHB_ARB_QUOTA_EN
    push_beats(0, 32'h1000, 0, 4, 16, 1'b0);
    push_beats(1, 32'h2000, 0, 1, 1, 1'b1);
    push_beats(0, 32'h1000, 4, 12, 16, 1'b0);
`else
    push_beats(0, 32'h1000, 0, 16, 16, 1'b0);
    push_beats(1, 32'h2000, 0, 1, 1, 1'b1);
`endif
    wait_drain("burst_holdoff");

    // both masters continuously requesting: strict alternation
    for (int r = 0; r < 4; r++) begin
      issue(0, 32'h3000 + 32'(16 * r), 1, 1'b0);
      issue(1, 32'h4000 + 32'(16 * r), 1, 1'b1);
      push_beats(0, 32'h3000 + 32'(16 * r), 0, 1, 1, 1'b0);
      push_beats(1, 32'h4000 + 32'(16 * r), 0, 1, 1, 1'b1);
    end
    wait_drain("alternate");

    // reset asserted while master 1 owns the bus mid-burst
    slave_en = 1'b0;
    issue(1, 32'h5000, 8, 1'b0);
    n = 0;
    do begin @(negedge wshb_clk); n++; end while (grant != 2'b10 && n < 20);
    check("rst_pre_grant", {grant, dbg_state, s_cyc}, 4'b1011);
    #2 wshb_rst = 1'b1;
    s_ack_f = 1'b1;
    #1 check("rst_async", {grant, s_cyc, s_stb, m_ack, dbg_state}, '0);
    s_ack_f = 1'b0;
    @(posedge wshb_clk);
    @(posedge wshb_clk); #1 wshb_rst = 1'b0;
    #1 slave_en = 1'b1;
    issue(0, 32'h6000, 1, 1'b0);
    issue(1, 32'h7000, 1, 1'b0);
    push_beats(0, 32'h6000, 0, 1, 1, 1'b0);
    push_beats(1, 32'h7000, 0, 1, 1, 1'b0);
    wait_drain("after_reset");

`ifdef WSHB_ARB_QUOTA_EN
    // quota of 4: master 0 pre-empted after its 4th ack, resumes after master 1
    issue(0, 32'h8000, 10, 1'b0);
    issue(1, 32'h9000, 1, 1'b1);
    push_beats(0, 32'h8000, 0, 4, 10, 1'b0);
    push_beats(1, 32'h9000, 0, 1, 1, 1'b1);
    push_beats(0, 32'h8000, 4, 6, 10, 1'b0);
    wait_drain("quota");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
